// File: rtl/acq_window_sequencer.sv
// Single-pixel-imaging acquisition sequencer: trigger -> settle -> gated photon counting -> result record.
// One record per projector pattern, handed to readout over a valid/ready handshake.
module acq_window_sequencer #(
    parameter int CNT_W  = 32,
    parameter int TIME_W = 24,
    parameter int IDX_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [TIME_W-1:0] settle_len,
    input  logic [TIME_W-1:0] gate_len,
    input  logic [IDX_W-1:0]  num_patterns,
    input  logic              pattern_trig,
    input  logic              pulse_a,
    input  logic              pulse_b,
    output logic              busy,
    output logic              gate,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [IDX_W-1:0]  res_idx,
    output logic [CNT_W-1:0]  res_cnt_a,
    output logic [CNT_W-1:0]  res_cnt_b,
    output logic [CNT_W-1:0]  res_cnt_ab,
    output logic [1:0]        res_flags,
    output logic              done
);
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_ARMED     = 3'd1;
    localparam logic [2:0] ST_SETTLE    = 3'd2;
    localparam logic [2:0] ST_INTEGRATE = 3'd3;
    localparam logic [2:0] ST_REPORT    = 3'd4;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [2:0]        state_reg;
    logic [TIME_W-1:0] settle_cfg_reg, gate_cfg_reg, timer_reg;
    logic [IDX_W-1:0]  npat_cfg_reg, idx_reg, idx_inc;
    logic              trig_d_reg, pulse_a_d_reg, pulse_b_d_reg;
    logic [CNT_W-1:0]  cnt_a_reg, cnt_b_reg, cnt_ab_reg;
    logic              sat_reg, miss_pend_reg, miss_rep_reg;
    logic              gate_reg, valid_reg, done_reg;
    logic              trig_edge, edge_a, edge_b, edge_ab, sat_hit;
    logic              go_integrate, last_pattern;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c, input logic ev);
        return (ev && c != CNT_MAX) ? c + CNT_W'(1) : c;
    endfunction

    assign trig_edge = pattern_trig & ~trig_d_reg;
    assign edge_a    = pulse_a & ~pulse_a_d_reg;
    assign edge_b    = pulse_b & ~pulse_b_d_reg;
    assign edge_ab   = edge_a & edge_b;
    assign sat_hit   = (edge_a && cnt_a_reg == CNT_MAX) || (edge_b && cnt_b_reg == CNT_MAX)
                    || (edge_ab && cnt_ab_reg == CNT_MAX);
    assign idx_inc   = idx_reg + IDX_W'(1);
    assign last_pattern = (npat_cfg_reg != '0) && (idx_inc == npat_cfg_reg);
    // Zero settle skips SETTLE entirely so the gate opens the cycle after the trigger.
    assign go_integrate = !abort &&
        (((state_reg == ST_ARMED) && trig_edge && settle_cfg_reg == '0) ||
         ((state_reg == ST_SETTLE) && timer_reg == TIME_W'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            settle_cfg_reg <= '0;
            gate_cfg_reg   <= '0;
            timer_reg      <= '0;
            npat_cfg_reg   <= '0;
            idx_reg        <= '0;
            trig_d_reg     <= 1'b0;
            pulse_a_d_reg  <= 1'b0;
            pulse_b_d_reg  <= 1'b0;
            cnt_a_reg      <= '0;
            cnt_b_reg      <= '0;
            cnt_ab_reg     <= '0;
            sat_reg        <= 1'b0;
            miss_pend_reg  <= 1'b0;
            miss_rep_reg   <= 1'b0;
            gate_reg       <= 1'b0;
            valid_reg      <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            trig_d_reg    <= pattern_trig;
            pulse_a_d_reg <= pulse_a;
            pulse_b_d_reg <= pulse_b;
            done_reg      <= 1'b0;
            if (gate_reg) begin
                cnt_a_reg  <= sat_add(cnt_a_reg, edge_a);
                cnt_b_reg  <= sat_add(cnt_b_reg, edge_b);
                cnt_ab_reg <= sat_add(cnt_ab_reg, edge_ab);
                if (sat_hit)
                    sat_reg <= 1'b1;
            end
            if (abort) begin
                state_reg <= ST_IDLE;
                gate_reg  <= 1'b0;
                valid_reg <= 1'b0;
            end else begin
                case (state_reg)
                    ST_IDLE: if (start) begin
                        settle_cfg_reg <= settle_len;
                        gate_cfg_reg   <= (gate_len == '0) ? TIME_W'(1) : gate_len;
                        npat_cfg_reg   <= num_patterns;
                        idx_reg        <= '0;
                        sat_reg        <= 1'b0;
                        miss_pend_reg  <= 1'b0;
                        miss_rep_reg   <= 1'b0;
                        state_reg      <= ST_ARMED;
                    end
                    ST_ARMED: if (trig_edge && settle_cfg_reg != '0) begin
                        timer_reg <= settle_cfg_reg;
                        state_reg <= ST_SETTLE;
                    end
                    ST_SETTLE: begin
                        miss_pend_reg <= miss_pend_reg | trig_edge;
                        timer_reg     <= timer_reg - TIME_W'(1);
                    end
                    ST_INTEGRATE: begin
                        // Misses up to the last gate cycle belong to this record; later ones to the next.
                        if (timer_reg == TIME_W'(1)) begin
                            state_reg     <= ST_REPORT;
                            gate_reg      <= 1'b0;
                            valid_reg     <= 1'b1;
                            miss_rep_reg  <= miss_pend_reg | trig_edge;
                            miss_pend_reg <= 1'b0;
                        end else begin
                            miss_pend_reg <= miss_pend_reg | trig_edge;
                            timer_reg     <= timer_reg - TIME_W'(1);
                        end
                    end
                    ST_REPORT: begin
                        miss_pend_reg <= miss_pend_reg | trig_edge;
                        if (res_ready) begin
                            valid_reg <= 1'b0;
                            idx_reg   <= idx_inc;
                            done_reg  <= last_pattern;
                            state_reg <= last_pattern ? ST_IDLE : ST_ARMED;
                        end
                    end
                    default: state_reg <= ST_IDLE;
                endcase
            end
            if (go_integrate) begin
                state_reg  <= ST_INTEGRATE;
                timer_reg  <= gate_cfg_reg;
                gate_reg   <= 1'b1;
                cnt_a_reg  <= '0;
                cnt_b_reg  <= '0;
                cnt_ab_reg <= '0;
                sat_reg    <= 1'b0;
            end
        end
    end

    assign busy       = (state_reg != ST_IDLE);
    assign gate       = gate_reg;
    assign res_valid  = valid_reg;
    assign res_idx    = idx_reg;
    assign res_cnt_a  = cnt_a_reg;
    assign res_cnt_b  = cnt_b_reg;
    assign res_cnt_ab = cnt_ab_reg;
    assign res_flags  = {miss_rep_reg, sat_reg};
    assign done       = done_reg;
endmodule
